// File: rtl/mem_arb_pkg.sv
// Shared types and constants for the instruction/data memory arbiter.
// Imported by the arbiter top and its watchdog.
package mem_arb_pkg;

  typedef enum logic [1:0] {
    ARB_IDLE    = 2'd0,
    ARB_BUSY    = 2'd1,
    ARB_RELEASE = 2'd2
  } arb_state_e;

  localparam logic PORT_FETCH = 1'b0;
  localparam logic PORT_LSU   = 1'b1;

  localparam logic [1:0] GRANT_NONE  = 2'b00;
  localparam logic [1:0] GRANT_FETCH = 2'b01;
  localparam logic [1:0] GRANT_LSU   = 2'b10;

  function automatic logic [1:0] port_grant(
    input logic port
  );
    return port ? GRANT_LSU : GRANT_FETCH;
  endfunction

endpackage

// File: rtl/mem_watchdog.sv
// Busy-cycle counter that flags a hung memory transaction.
// TIMEOUT of zero disables the expiry flag entirely.
module mem_watchdog
  import mem_arb_pkg::*;
#(
  parameter int TIMEOUT = 255
) (
  input  logic clk,
  input  logic reset,
  input  logic clear,
  input  logic enable,
  output logic expired
);

  localparam logic [15:0] LIMIT = 16'(TIMEOUT);

  logic [15:0] count;

  // Saturate at the limit so a stuck enable never wraps around.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      count <= '0;
    end else if (clear) begin
      count <= '0;
    end else if (enable && count != LIMIT) begin
      count <= count + 16'd1;
    end
  end

  assign expired = (TIMEOUT != 0) && (count == LIMIT);

endmodule

// File: rtl/mem_arbiter.sv
// Round-robin arbiter sharing one memory port between fetch and LSU.
// All outputs are registered; a watchdog aborts hung transactions.
module mem_arbiter
  import mem_arb_pkg::*;
#(
  parameter int AW      = 32,
  parameter int DW      = 32,
  parameter int TIMEOUT = 255
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          p0_en,
  input  logic [AW-1:0] p0_addr,
  output logic [DW-1:0] p0_do,
  output logic          p0_do_ack,
  output logic          p0_err,
  input  logic          p1_en,
  input  logic          p1_we,
  input  logic [AW-1:0] p1_addr,
  input  logic [DW-1:0] p1_di,
  output logic [DW-1:0] p1_do,
  output logic          p1_do_ack,
  output logic          p1_err,
  output logic          mem_en,
  output logic          mem_we,
  output logic [AW-1:0] mem_addr,
  output logic [DW-1:0] mem_di,
  input  logic [DW-1:0] mem_do,
  input  logic          mem_do_ack,
  output logic [1:0]    grant
);

  arb_state_e state;
  logic       last_grant;
  logic       pick;
  logic       wd_clear;
  logic       wd_enable;
  logic       wd_expired;
  logic       finish;

  assign wd_clear  = (state != ARB_BUSY);
  assign wd_enable = (state == ARB_BUSY);
  assign finish    = mem_do_ack || wd_expired;

  mem_watchdog #(
    .TIMEOUT(TIMEOUT)
  ) u_watchdog (
    .clk    (clk),
    .reset  (reset),
    .clear  (wd_clear),
    .enable (wd_enable),
    .expired(wd_expired)
  );

  // On a tie the port that did not win last time goes next.
  always_comb begin
    pick = PORT_FETCH;
    if (p0_en && p1_en) begin
      pick = ~last_grant;
    end else if (p1_en) begin
      pick = PORT_LSU;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state      <= ARB_IDLE;
      last_grant <= PORT_LSU;
      grant      <= GRANT_NONE;
      mem_en     <= 1'b0;
      mem_we     <= 1'b0;
      mem_addr   <= '0;
      mem_di     <= '0;
      p0_do      <= '0;
      p0_do_ack  <= 1'b0;
      p0_err     <= 1'b0;
      p1_do      <= '0;
      p1_do_ack  <= 1'b0;
      p1_err     <= 1'b0;
    end else begin
      p0_do_ack <= 1'b0;
      p0_err    <= 1'b0;
      p1_do_ack <= 1'b0;
      p1_err    <= 1'b0;
      unique case (state)
        ARB_IDLE: begin
          if (p0_en || p1_en) begin
            if (pick == PORT_LSU) begin
              mem_we   <= p1_we;
              mem_addr <= p1_addr;
              mem_di   <= p1_di;
            end else begin
              mem_we   <= 1'b0;
              mem_addr <= p0_addr;
              mem_di   <= '0;
            end
            grant      <= port_grant(pick);
            mem_en     <= 1'b1;
            last_grant <= pick;
            state      <= ARB_BUSY;
          end
        end
        ARB_BUSY: begin
          if (finish) begin
            mem_en <= 1'b0;
            mem_we <= 1'b0;
            state  <= ARB_RELEASE;
            // A real ack beats a simultaneous expiry.
            if (grant == GRANT_LSU) begin
              p1_do_ack <= 1'b1;
              p1_err    <= ~mem_do_ack;
              p1_do     <= mem_do_ack ? mem_do : '0;
            end else begin
              p0_do_ack <= 1'b1;
              p0_err    <= ~mem_do_ack;
              p0_do     <= mem_do_ack ? mem_do : '0;
            end
          end
        end
        ARB_RELEASE: begin
          grant <= GRANT_NONE;
          state <= ARB_IDLE;
        end
        default: begin
          grant  <= GRANT_NONE;
          mem_en <= 1'b0;
          mem_we <= 1'b0;
          state  <= ARB_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mem_arbiter.sv
// Scoreboard bench for mem_arbiter: randomized rounds plus directed cases.
// Expected traffic comes from a round-robin/memory reference model.
module tb_mem_arbiter;

  localparam int TO = 4;

  typedef struct {
    logic        port;
    logic [31:0] addr;
    logic        we;
    logic [31:0] di;
  } req_t;

  typedef struct {
    logic        port;
    logic [31:0] data;
    logic        err;
    int          lat;
  } rsp_t;

  logic        clk;
  logic        reset;
  logic        p0_en;
  logic [31:0] p0_addr;
  logic [31:0] p0_do;
  logic        p0_do_ack;
  logic        p0_err;
  logic        p1_en;
  logic        p1_we;
  logic [31:0] p1_addr;
  logic [31:0] p1_di;
  logic [31:0] p1_do;
  logic        p1_do_ack;
  logic        p1_err;
  logic        mem_en;
  logic        mem_we;
  logic [31:0] mem_addr;
  logic [31:0] mem_di;
  logic [31:0] mem_do;
  logic        mem_do_ack;
  logic [1:0]  grant;

  int checks;
  int failures;
  int cyc;
  int last;
  bit spur;

  req_t req_q[$];
  rsp_t rsp_q[$];
  int   lat_q[$];

  logic [31:0] mem_arr[64];
  logic [31:0] ref_arr[64];

  mem_arbiter #(
    .AW(32),
    .DW(32),
    .TIMEOUT(TO)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .p0_en     (p0_en),
    .p0_addr   (p0_addr),
    .p0_do     (p0_do),
    .p0_do_ack (p0_do_ack),
    .p0_err    (p0_err),
    .p1_en     (p1_en),
    .p1_we     (p1_we),
    .p1_addr   (p1_addr),
    .p1_di     (p1_di),
    .p1_do     (p1_do),
    .p1_do_ack (p1_do_ack),
    .p1_err    (p1_err),
    .mem_en    (mem_en),
    .mem_we    (mem_we),
    .mem_addr  (mem_addr),
    .mem_di    (mem_di),
    .mem_do    (mem_do),
    .mem_do_ack(mem_do_ack),
    .grant     (grant)
  );

  initial begin
    clk = 0;
    forever #5 clk = ~clk;
  end

  initial begin
    cyc = 0;
    forever begin
      @(posedge clk);
      cyc++;
    end
  end

  // Memory device: acks lat cycles after the request, or never if
  // lat exceeds the watchdog limit.
  initial begin
    bit busy;
    int cnt;
    int lat;
    int idx;
    busy = 0;
    cnt = 0;
    lat = 0;
    mem_do_ack = 0;
    mem_do = 0;
    forever begin
      @(negedge clk);
      mem_do_ack = 0;
      mem_do = $urandom;
      if (reset) begin
        busy = 0;
      end else if (!mem_en) begin
        busy = 0;
        if (spur) begin
          mem_do_ack = 1;
          spur = 0;
        end
      end else begin
        if (!busy) begin
          busy = 1;
          lat = (lat_q.size() != 0) ? lat_q.pop_front() : 1000;
          cnt = lat;
        end else begin
          cnt--;
        end
        if (cnt == 0 && lat <= TO) begin
          idx = int'(mem_addr[7:2]);
          mem_do_ack = 1;
          mem_do = mem_arr[idx];
          if (mem_we) mem_arr[idx] = mem_di;
        end
      end
    end
  end

  // Monitor: checks every grant and every ack against the queues.
  initial begin
    bit   prev_en;
    int   rise;
    req_t r;
    rsp_t s;
    logic port;
    logic [31:0] data;
    logic err;
    prev_en = 0;
    rise = 0;
    forever begin
      @(negedge clk);
      if (reset) begin
        prev_en = 0;
        continue;
      end
      if (mem_en && !prev_en) begin
        rise = cyc;
        checks++;
        if (req_q.size() == 0) begin
          failures++;
          $display("FAIL req_unexpected grant=%b addr=%h required=none",
                   grant, mem_addr);
        end else begin
          r = req_q.pop_front();
          if (grant != (r.port ? 2'b10 : 2'b01) || mem_addr != r.addr ||
              mem_we != r.we || mem_di != r.di) begin
            failures++;
            $display("FAIL req grant=%b addr=%h we=%b di=%h required port=%0d addr=%h we=%b di=%h",
                     grant, mem_addr, mem_we, mem_di,
                     r.port, r.addr, r.we, r.di);
          end
        end
      end
      prev_en = mem_en;
      if (p0_do_ack || p1_do_ack) begin
        checks++;
        port = p1_do_ack;
        data = port ? p1_do : p0_do;
        err  = port ? p1_err : p0_err;
        if (p0_do_ack && p1_do_ack) begin
          failures++;
          $display("FAIL ack_overlap p0_do_ack=1 p1_do_ack=1 required=one");
        end else if (rsp_q.size() == 0) begin
          failures++;
          $display("FAIL ack_unexpected port=%0d data=%h required=none",
                   port, data);
        end else begin
          s = rsp_q.pop_front();
          if (port != s.port || data != s.data || err != s.err ||
              (cyc - rise) != s.lat) begin
            failures++;
            $display("FAIL rsp port=%0d data=%h err=%b lat=%0d required port=%0d data=%h err=%b lat=%0d",
                     port, data, err, cyc - rise,
                     s.port, s.data, s.err, s.lat);
          end
        end
      end else if (p0_err || p1_err) begin
        checks++;
        failures++;
        $display("FAIL err_no_ack p0_err=%b p1_err=%b required=0",
                 p0_err, p1_err);
      end
    end
  end

  task automatic check_idle_zero(input string name);
    checks++;
    if (grant != 0 || mem_en || mem_we || mem_addr != 0 ||
        mem_di != 0 || p0_do != 0 || p1_do != 0 || p0_do_ack ||
        p1_do_ack || p0_err || p1_err) begin
      failures++;
      $display("FAIL %s grant=%b mem_en=%b mem_we=%b addr=%h di=%h p0_do=%h p1_do=%h acks=%b%b errs=%b%b required=all0",
               name, grant, mem_en, mem_we, mem_addr, mem_di,
               p0_do, p1_do, p0_do_ack, p1_do_ack, p0_err, p1_err);
    end
  endtask

  // Reference model: predicts order, memory contents and outcome.
  task automatic do_round(
    input int          mask,
    input logic [31:0] a0,
    input logic [31:0] a1,
    input logic [31:0] d1,
    input logic        w1,
    input int          l0,
    input int          l1
  );
    int   order[$];
    int   lats[2];
    int   p;
    int   idx;
    bit   ok;
    bit   pend0;
    bit   pend1;
    int   n;
    req_t r;
    rsp_t s;
    lats[0] = l0;
    lats[1] = l1;
    if (mask == 3) begin
      order.push_back(last == 0 ? 1 : 0);
      order.push_back(last == 0 ? 0 : 1);
    end else begin
      order.push_back(mask == 2 ? 1 : 0);
    end
    foreach (order[k]) begin
      p = order[k];
      r.port = p[0];
      r.addr = p ? a1 : a0;
      r.we   = p ? w1 : 1'b0;
      r.di   = p ? d1 : 32'h0;
      req_q.push_back(r);
      idx = int'(r.addr[7:2]);
      ok = lats[p] <= TO;
      s.port = p[0];
      s.err  = !ok;
      s.data = ok ? ref_arr[idx] : 32'h0;
      s.lat  = ok ? lats[p] + 1 : TO + 1;
      rsp_q.push_back(s);
      if (ok && r.we) ref_arr[idx] = d1;
      lat_q.push_back(lats[p]);
      last = p;
    end
    @(negedge clk);
    p0_en   = mask[0];
    p0_addr = a0;
    p1_en   = mask[1];
    p1_addr = a1;
    p1_di   = d1;
    p1_we   = w1;
    pend0 = mask[0];
    pend1 = mask[1];
    n = 0;
    while ((pend0 || pend1) && n < 60) begin
      @(negedge clk);
      n++;
      if (p0_do_ack && pend0) begin
        pend0 = 0;
        p0_en = 0;
        p0_addr = $urandom;
      end
      if (p1_do_ack && pend1) begin
        pend1 = 0;
        p1_en = 0;
        p1_addr = $urandom;
        p1_di = $urandom;
        p1_we = $urandom_range(0, 1);
      end
    end
    if (pend0 || pend1) begin
      checks++;
      failures++;
      $display("FAIL round_timeout pending=%b%b required=00",
               pend1, pend0);
      p0_en = 0;
      p1_en = 0;
    end
  endtask

  function automatic logic [31:0] raddr();
    return {24'h0, 6'($urandom_range(0, 63)), 2'b00};
  endfunction

  initial begin
    logic [31:0] tmp;
    checks = 0;
    failures = 0;
    last = 1;
    spur = 0;
    for (int i = 0; i < 64; i++) begin
      tmp = $urandom;
      mem_arr[i] = tmp;
      ref_arr[i] = tmp;
    end
    mem_arr[4] = 32'hDEADBEEF;
    ref_arr[4] = 32'hDEADBEEF;
    reset = 1;
    p0_en = 0;
    p0_addr = 0;
    p1_en = 0;
    p1_we = 0;
    p1_addr = 0;
    p1_di = 0;
    #1;
    check_idle_zero("reset_state");
    @(negedge clk);
    @(negedge clk);
    reset = 0;

    do_round(1, 32'h10, 32'h0, 32'h0, 1'b0, 2, 0);
    do_round(2, 32'h0, 32'h40, 32'h12345678, 1'b1, 0, 0);
    for (int i = 0; i < 3; i++)
      do_round(3, raddr(), raddr(), $urandom, 1'($urandom_range(0, 1)),
               $urandom_range(0, 3), $urandom_range(0, 3));
    do_round(1, 32'h20, 32'h0, 32'h0, 1'b0, 1000, 0);
    do_round(2, 32'h0, 32'h24, 32'h0, 1'b0, 0, TO);

    @(negedge clk);
    #1 spur = 1;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      checks++;
      if (mem_en || grant != 0 || p0_do_ack || p1_do_ack) begin
        failures++;
        $display("FAIL spurious_ack mem_en=%b grant=%b acks=%b%b required=0",
                 mem_en, grant, p0_do_ack, p1_do_ack);
      end
    end

    for (int i = 0; i < 40; i++)
      do_round($urandom_range(1, 3), raddr(), raddr(), $urandom,
               1'($urandom_range(0, 1)), $urandom_range(0, 6),
               $urandom_range(0, 6));

    req_q.push_back('{port: 1'b1, addr: 32'h80, we: 1'b1,
                      di: 32'hA5A5A5A5});
    lat_q.push_back(1000);
    @(negedge clk);
    p1_en = 1;
    p1_we = 1;
    p1_addr = 32'h80;
    p1_di = 32'hA5A5A5A5;
    @(negedge clk);
    @(negedge clk);
    #2 reset = 1;
    #1 check_idle_zero("reset_mid_busy");
    p1_en = 0;
    p1_we = 0;
    last = 1;
    @(negedge clk);
    @(negedge clk);
    check_idle_zero("reset_held");
    reset = 0;
    do_round(3, raddr(), raddr(), $urandom, 1'b0, 1, 1);

    for (int i = 0; i < 10; i++)
      do_round($urandom_range(1, 3), raddr(), raddr(), $urandom,
               1'($urandom_range(0, 1)), $urandom_range(0, 6),
               $urandom_range(0, 6));

    repeat (4) @(negedge clk);
    checks++;
    if (req_q.size() != 0 || rsp_q.size() != 0) begin
      failures++;
      $display("FAIL drain req_left=%0d rsp_left=%0d required=0",
               req_q.size(), rsp_q.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/mem_arbiter.md
# mem_arbiter

Two-port arbiter that shares the single instruction/data memory port between the instruction fetch stage (port 0, read-only) and the load/store stage (port 1, read/write). It sits between the pipeline stages and the memory controller. Each requester keeps its existing level-held `en` / pulsed `do_ack` protocol unchanged. It provides round-robin fairness, registered request capture, and a watchdog timeout so a hung memory cannot stall the pipeline forever.

## Interface
Parameters:
- `AW`, 32, address width
- `DW`, 32, data width
- `TIMEOUT`, 255, number of BUSY cycles without `mem_do_ack` before abort; 0 disables the watchdog; range 0..65535

Ports:
- `clk`  in  1  single clock, rising edge
- `reset`  in  1  asynchronous, active-high; all state and outputs cleared immediately
- `p0_en`  in  1  fetch request, held high until its ack is seen
- `p0_addr`  in  AW  fetch address
- `p0_do`  out  DW  read data to fetch
- `p0_do_ack`  out  1  one-cycle completion pulse to fetch
- `p0_err`  out  1  qualifies `p0_do_ack`: transaction timed out
- `p1_en`, `p1_we`, `p1_addr`, `p1_di`  in  1/1/AW/DW  load/store request, write enable, address, write data
- `p1_do`, `p1_do_ack`, `p1_err`  out  DW/1/1  as for port 0
- `mem_en`, `mem_we`  out  1/1  memory request, write enable
- `mem_addr`, `mem_di`  out  AW/DW  memory address, write data
- `mem_do`  in  DW  memory read data
- `mem_do_ack`  in  1  memory completion pulse
- `grant`  out  2  one-hot owner of the memory port; 00 when idle

## Operation
- States: IDLE, BUSY, RELEASE.
- **IDLE**:
  - If no `en` is high, stay in IDLE.
  - If exactly one `en` is high, grant that port.
  - If both are high, grant the port other than `last_grant`.
  - On grant: latch addr, di, and we into registers; we = 0 for port 0. Set `grant`, set `mem_en`=1, clear the watchdog counter, update `last_grant`, go to BUSY.
- **BUSY**:
  - `mem_en` stays high. Memory outputs come only from the latched registers, so requester input changes are ignored.
  - On `mem_do_ack`: register `mem_do` into the granted `pN_do`, pulse `pN_do_ack`=1 with `pN_err`=0, drop `mem_en` and `mem_we`, go to RELEASE.
  - Otherwise increment the counter. When the counter reaches `TIMEOUT` (and `TIMEOUT` != 0): pulse `pN_do_ack`=1 with `pN_err`=1 and `pN_do`=0, drop `mem_en`, go to RELEASE.
  - If `mem_do_ack` and timeout occur in the same cycle, the ack wins (err=0).
- **RELEASE**: one cycle in which the requester consumes its ack and drops `en`. Clear `grant`, go to IDLE.
- A requester that drops `en` while in BUSY does not abort the transaction; its ack is still delivered.
- `mem_do_ack` seen in IDLE or RELEASE is ignored and is not forwarded.
- `pN_do` holds its last value between transactions.
- Reset values: state=IDLE, `last_grant`=port 1 (so port 0 wins the first tie). All outputs are 0: `grant`=00, `mem_en`=0, `mem_we`=0, `mem_addr`=0, `mem_di`=0, `pN_do`=0, `pN_do_ack`=0, `pN_err`=0.
- Reset asserted mid-BUSY abandons the transaction with no ack to either port. The memory controller is reset by the same signal.

## Timing
- All outputs are registered.
- `en` sampled high at edge 1 → `mem_en`, `grant`, and latched address valid from cycle 1.
- `mem_do_ack` in cycle k → `pN_do_ack` and `pN_do` valid in cycle k+1 (RELEASE) → IDLE in cycle k+2, where a new grant can be made.
- Zero-wait memory (ack in cycle 1): ack to requester in cycle 2; back-to-back grants every 3 cycles.
- Under constant contention the grant alternates 0,1,0,1…; no port waits longer than one foreign transaction plus 2 cycles.
- Timeout ack is asserted exactly `TIMEOUT`+1 cycles after `mem_en` rises, provided no `mem_do_ack` arrived.
- `pN_do_ack` and `pN_err` are single-cycle pulses, never high for both ports in the same cycle.

## Structure
- Shared package `mem_arb_pkg`:
  - state encoding: ARB_IDLE=2'd0, ARB_BUSY=2'd1, ARB_RELEASE=2'd2
  - port index constants: PORT_FETCH=0, PORT_LSU=1
  - grant one-hot constants
- Sub-module `mem_watchdog`:
  - 16-bit counter with clear, enable, and `TIMEOUT` parameter
  - outputs a `expired` level
  - `TIMEOUT`=0 ties `expired` to 0
- Target: arbiter top plus watchdog, ~200 lines.

## Test plan
- **Single fetch**: `p0_en`=1, `p0_addr`=0x10, memory acks 2 cycles after `mem_en` with `mem_do`=0xDEADBEEF → `mem_addr`=0x10, `mem_we`=0, `p0_do`=0xDEADBEEF, `p0_do_ack` for one cycle, `grant` 01→00.
- **Store**: `p1_en`=1, `p1_we`=1, `p1_addr`=0x40, `p1_di`=0x12345678, zero-wait memory → `mem_we`=1, `mem_di`=0x12345678 in cycle 1, `p1_do_ack` in cycle 2, IDLE in cycle 3.
- **Contention**: both `en` held high for 6 transactions after reset → grant order 0,1,0,1,0,1, with no `p0_do_ack`/`p1_do_ack` overlap.
- **Timeout**: `TIMEOUT`=4, memory never acks → `pN_do_ack`=1 with `pN_err`=1 and `pN_do`=0 exactly 5 cycles after `mem_en` rises, then `mem_en`=0. Repeat with ack arriving on the expiry cycle → `pN_err`=0.
- **Reset mid-BUSY**: assert `reset` between clock edges while port 1 is granted → all outputs 0 immediately, no ack pulse; after release, both `en` high → port 0 granted first.
- **Spurious ack**: `mem_do_ack` pulsed while in IDLE → no `pN_do_ack` and no state change.
